// File: rtl/key_debounce_pkg.sv
// Shared types for the key debounce bank: per-channel FSM state encoding.
package key_debounce_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ARM_PRS = 2'd1,
    PRESSED = 2'd2,
    ARM_REL = 2'd3
  } state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, polarity fix, tick-driven debounce FSM
// with stable/hold counters, and registered level and pulse outputs.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_key,
  output logic o_key,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int SC_W = $clog2(STABLE_TICKS + 1);
  localparam int HC_W = $clog2(LONG_TICKS + 1);
  localparam logic [SC_W-1:0] SC_DONE = SC_W'(STABLE_TICKS);
  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
  localparam logic [HC_W-1:0] HC_LONG = HC_W'(LONG_TICKS);
  localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);
  localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic            r_sync1, r_sync2;
  state_e          r_state, w_state_n;
  logic [SC_W-1:0] r_sc, w_sc_n;
  logic [HC_W-1:0] r_hc, w_hc_n;
  logic            r_key, w_key_n;
  logic            r_press, w_press_n;
  logic            r_rel, w_rel_n;
  logic            r_long, w_long_n;
  logic            w_s;

  // Synced level normalised so that 1 always means pressed.
  assign w_s = r_sync2 ^ REL_LVL;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= REL_LVL;
      r_sync2 <= REL_LVL;
      r_state <= IDLE;
      r_sc    <= '0;
      r_hc    <= '0;
      r_key   <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_state <= w_state_n;
      r_sc    <= w_sc_n;
      r_hc    <= w_hc_n;
      r_key   <= w_key_n;
      r_press <= w_press_n;
      r_rel   <= w_rel_n;
      r_long  <= w_long_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_sc_n    = r_sc;
    w_hc_n    = r_hc;
    w_key_n   = r_key;
    w_press_n = 1'b0;
    w_rel_n   = 1'b0;
    w_long_n  = 1'b0;
    if (i_tick) begin
      case (r_state)
        IDLE: begin
          if (w_s) begin
            if (SC_DONE == SC_ONE) begin
              w_state_n = PRESSED;
              w_key_n   = 1'b1;
              w_press_n = 1'b1;
              w_hc_n    = '0;
              w_sc_n    = '0;
            end else begin
              w_state_n = ARM_PRS;
              w_sc_n    = SC_ONE;
            end
          end
        end
        ARM_PRS: begin
          if (!w_s) begin
            w_state_n = IDLE;
            w_sc_n    = '0;
          end else if ((r_sc + SC_ONE) == SC_DONE) begin
            w_state_n = PRESSED;
            w_key_n   = 1'b1;
            w_press_n = 1'b1;
            w_hc_n    = '0;
            w_sc_n    = '0;
          end else begin
            w_sc_n = r_sc + SC_ONE;
          end
        end
        PRESSED: begin
          // Hold count saturates, so long fires once per hold even across bounces.
          if (w_s) begin
            if (r_hc != HC_LONG) begin
              w_hc_n   = r_hc + HC_ONE;
              w_long_n = ((r_hc + HC_ONE) == HC_LONG);
            end
          end else if (SC_DONE == SC_ONE) begin
            w_state_n = IDLE;
            w_key_n   = 1'b0;
            w_rel_n   = 1'b1;
            w_sc_n    = '0;
          end else begin
            w_state_n = ARM_REL;
            w_sc_n    = SC_ONE;
          end
        end
        ARM_REL: begin
          if (w_s) begin
            w_state_n = PRESSED;
            w_sc_n    = '0;
          end else if ((r_sc + SC_ONE) == SC_DONE) begin
            w_state_n = IDLE;
            w_key_n   = 1'b0;
            w_rel_n   = 1'b1;
            w_sc_n    = '0;
          end else begin
            w_sc_n = r_sc + SC_ONE;
          end
        end
        default: begin
          w_state_n = IDLE;
          w_sc_n    = '0;
        end
      endcase
    end
  end

  assign o_key     = r_key;
  assign o_press   = r_press;
  assign o_release = r_rel;
  assign o_long    = r_long;

endmodule

// File: rtl/key_debounce.sv
// Key bank conditioner: one shared debounce tick divider feeding an
// independent debounce channel per key.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_KEYS-1:0] key_i,
  output logic [N_KEYS-1:0] key_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic [N_KEYS-1:0] long_o
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_cnt == TICK_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_ch (
      .i_clk    (clk_i),
      .i_rst_n  (rst_n_i),
      .i_tick   (w_tick),
      .i_key    (key_i[g]),
      .o_key    (key_o[g]),
      .o_press  (press_o[g]),
      .o_release(release_o[g]),
      .o_long   (long_o[g])
    );
  end

endmodule
